move_sequencer: RTL and testbench

MOVE_SEQUENCER -- requirements
Module: move_sequencer

---
 rtl/move_sequencer.sv | 142 ++++++++++++++
 tb/tb_move_sequencer.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/move_sequencer.sv
// Connect-four move sequencer: validates column drops, tracks occupancy,
// hands each new piece to the VGA drawer and alternates turns.
// Ports:
//   clock, reset          - sole clock, synchronous active-high reset
//   move_valid/move_col   - requested column; accepted when move_ready
//   move_ready            - high only while idle
//   move_reject           - one-cycle pulse for an illegal move
//   draw_req/col/row/player, draw_done - piece handoff to the drawer
//   player, col_occ, board_full        - game state
module move_sequencer #(
  parameter int NUM_COLS = 7,
  parameter int NUM_ROWS = 6
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         move_valid,
  input  logic [2:0]                   move_col,
  output logic                         move_ready,
  output logic                         move_reject,
  output logic                         draw_req,
  output logic [2:0]                   draw_col,
  output logic [2:0]                   draw_row,
  output logic                         draw_player,
  input  logic                         draw_done,
  output logic                         player,
  output logic [NUM_COLS*NUM_ROWS-1:0] col_occ,
  output logic                         board_full
);

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    REJECT,
    DRAW,
    TURN,
    FULL
  } state_t;

  localparam logic [3:0] COLS  = 4'(NUM_COLS);
  localparam logic [5:0] TOTAL = 6'(NUM_COLS * NUM_ROWS);
  localparam logic [2:0] BOT   = 3'(NUM_ROWS - 1);

  state_t              state;
  logic [2:0]          col_q;
  logic [5:0]          cnt;
  logic [NUM_ROWS-1:0] sel;
  logic [2:0]          ones;
  logic                col_bad;
  logic [5:0]          cnt_inc;

  // Occupancy of the latched column; an out-of-range column reads as
  // empty but is rejected by col_bad anyway.
  always_comb begin
    sel = '0;
    for (int c = 0; c < NUM_COLS; c++) begin
      if (col_q == 3'(c)) sel = col_occ[c*NUM_ROWS +: NUM_ROWS];
    end
  end

  always_comb begin
    ones = '0;
    for (int i = 0; i < NUM_ROWS; i++) begin
      ones = ones + {2'b00, sel[i]};
    end
  end

  assign col_bad = ({1'b0, col_q} >= COLS) || sel[NUM_ROWS-1];
  assign cnt_inc = cnt + 6'd1;

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      col_q       <= '0;
      cnt         <= '0;
      player      <= 1'b0;
      col_occ     <= '0;
      board_full  <= 1'b0;
      move_ready  <= 1'b1;
      move_reject <= 1'b0;
      draw_req    <= 1'b0;
      draw_col    <= '0;
      draw_row    <= '0;
      draw_player <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (move_valid) begin
            col_q      <= move_col;
            move_ready <= 1'b0;
            state      <= CHECK;
          end
        end
        CHECK: begin
          if (col_bad) begin
            move_reject <= 1'b1;
            state       <= REJECT;
          end else begin
            for (int c = 0; c < NUM_COLS; c++) begin
              if (col_q == 3'(c)) begin
                col_occ[c*NUM_ROWS +: NUM_ROWS] <=
                  {sel[NUM_ROWS-2:0], 1'b1};
              end
            end
            draw_row    <= BOT - ones;
            draw_col    <= col_q;
            draw_player <= player;
            draw_req    <= 1'b1;
            state       <= DRAW;
          end
        end
        REJECT: begin
          move_reject <= 1'b0;
          move_ready  <= 1'b1;
          state       <= IDLE;
        end
        DRAW: begin
          if (draw_done) begin
            draw_req <= 1'b0;
            state    <= TURN;
          end
        end
        TURN: begin
          player <= ~player;
          cnt    <= cnt_inc;
          if (cnt_inc == TOTAL) begin
            board_full <= 1'b1;
            state      <= FULL;
          end else begin
            move_ready <= 1'b1;
            state      <= IDLE;
          end
        end
        FULL: begin
          move_ready <= 1'b0;
          board_full <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_move_sequencer.sv
// Testbench for move_sequencer: directed and random moves checked
// against a column-height game model.
module tb_move_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        move_valid = 1'b0;
  logic [2:0]  move_col = '0;
  logic        move_ready;
  logic        move_reject;
  logic        draw_req;
  logic [2:0]  draw_col;
  logic [2:0]  draw_row;
  logic        draw_player;
  logic        draw_done = 1'b0;
  logic        player;
  logic [41:0] col_occ;
  logic        board_full;

  int vectors = 0;
  int errors  = 0;

  int h [7];
  bit pl;
  int moves;

  move_sequencer dut (
    .clock      (clock),
    .reset      (reset),
    .move_valid (move_valid),
    .move_col   (move_col),
    .move_ready (move_ready),
    .move_reject(move_reject),
    .draw_req   (draw_req),
    .draw_col   (draw_col),
    .draw_row   (draw_row),
    .draw_player(draw_player),
    .draw_done  (draw_done),
    .player     (player),
    .col_occ    (col_occ),
    .board_full (board_full)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [41:0] exp_occ();
    logic [41:0] v;
    v = '0;
    for (int c = 0; c < 7; c++) begin
      for (int r = 0; r < h[c]; r++) v[c*6 + r] = 1'b1;
    end
    return v;
  endfunction

  function automatic bit is_full();
    return moves == 42;
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic model_reset();
    for (int c = 0; c < 7; c++) h[c] = 0;
    pl = 1'b0;
    moves = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    move_valid = 1'b0;
    draw_done = 1'b0;
    step();
    step();
    reset = 1'b0;
    model_reset();
    chk("rst_ready", 64'(move_ready), 64'd1);
    chk("rst_occ", 64'(col_occ), 64'd0);
    chk("rst_player", 64'(player), 64'd0);
    chk("rst_full", 64'(board_full), 64'd0);
    chk("rst_dreq", 64'(draw_req), 64'd0);
    chk("rst_rej", 64'(move_reject), 64'd0);
    chk("rst_dfields", 64'({draw_col, draw_row, draw_player}), 64'd0);
  endtask

  task automatic do_move(input int col, input int stall, input bit hold);
    bit legal;
    int row;
    legal = (col < 7) && (h[col] < 6);
    row = (col < 7) ? 5 - h[col] : 0;
    chk("pre_ready", 64'(move_ready), 64'd1);
    move_col = 3'(col);
    move_valid = 1'b1;
    step();
    if (hold) move_col = 3'($urandom_range(0, 7));
    else move_valid = 1'b0;
    draw_done = 1'($urandom_range(0, 1));
    chk("busy_ready", 64'(move_ready), 64'd0);
    chk("busy_dreq", 64'(draw_req), 64'd0);
    step();
    if (legal) begin
      chk("draw_req", 64'(draw_req), 64'd1);
      chk("draw_col", 64'(draw_col), 64'(col));
      chk("draw_row", 64'(draw_row), 64'(row));
      chk("draw_pl", 64'(draw_player), 64'(pl));
      chk("no_rej", 64'(move_reject), 64'd0);
      draw_done = 1'b0;
      for (int i = 0; i < stall; i++) begin
        step();
        chk("stall_dreq", 64'(draw_req), 64'd1);
        chk("stall_fields", 64'({draw_col, draw_row, draw_player}),
            64'({3'(col), 3'(row), pl}));
        chk("stall_ready", 64'(move_ready), 64'd0);
      end
      draw_done = 1'b1;
      step();
      move_valid = 1'b0;
      draw_done = 1'($urandom_range(0, 1));
      chk("turn_dreq", 64'(draw_req), 64'd0);
      chk("turn_ready", 64'(move_ready), 64'd0);
      h[col]++;
      pl = ~pl;
      moves++;
      step();
      draw_done = 1'b0;
      chk("post_ready", 64'(move_ready), 64'(!is_full()));
      chk("post_full", 64'(board_full), 64'(is_full()));
      chk("post_player", 64'(player), 64'(pl));
      chk("post_occ", 64'(col_occ), 64'(exp_occ()));
    end else begin
      chk("rej_pulse", 64'(move_reject), 64'd1);
      chk("rej_dreq", 64'(draw_req), 64'd0);
      move_valid = 1'b0;
      step();
      draw_done = 1'b0;
      chk("rej_end", 64'(move_reject), 64'd0);
      chk("rej_ready", 64'(move_ready), 64'd1);
      chk("rej_occ", 64'(col_occ), 64'(exp_occ()));
      chk("rej_player", 64'(player), 64'(pl));
    end
  endtask

  initial begin
    model_reset();
    step();
    do_reset();

    // single drop into column 3
    do_move(3, 0, 1'b0);

    // fill column 0, then overflow it
    do_reset();
    for (int i = 0; i < 6; i++) do_move(0, 0, 1'b0);
    do_move(0, 0, 1'b0);

    // out-of-range column, rightmost legal column
    do_reset();
    do_move(7, 0, 1'b0);
    do_move(6, 0, 1'b0);

    // drawer stalls for 10 cycles, requester keeps move_valid up
    do_move(2, 10, 1'b1);

    // reset in the middle of a draw
    move_col = 3'd4;
    move_valid = 1'b1;
    step();
    move_valid = 1'b0;
    step();
    chk("mid_dreq", 64'(draw_req), 64'd1);
    reset = 1'b1;
    step();
    chk("mid_rst_dreq", 64'(draw_req), 64'd0);
    chk("mid_rst_occ", 64'(col_occ), 64'd0);
    chk("mid_rst_pl", 64'(player), 64'd0);
    reset = 1'b0;
    model_reset();
    chk("mid_rel_ready", 64'(move_ready), 64'd1);

    // random game moves
    for (int i = 0; i < 40; i++) begin
      do_move($urandom_range(0, 7), $urandom_range(0, 3),
              1'($urandom_range(0, 1)));
    end

    // fill the board column by column
    do_reset();
    for (int c = 0; c < 7; c++) begin
      for (int r = 0; r < 6; r++) do_move(c, $urandom_range(0, 1), 1'b0);
    end
    move_col = 3'd1;
    move_valid = 1'b1;
    draw_done = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("full_ready", 64'(move_ready), 64'd0);
      chk("full_flag", 64'(board_full), 64'd1);
      chk("full_dreq", 64'(draw_req), 64'd0);
      chk("full_occ", 64'(col_occ), 64'(exp_occ()));
    end
    move_valid = 1'b0;
    draw_done = 1'b0;

    do_reset();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
